mapper_sdram_read_bridge: RTL and testbench

//  Downstream stage of the cartridge mapper blocks. Takes the mapper's resolved read
//  (ram_cs + 27-bit linear addr) and turns each CPU read cycle into one SDRAM read.

---
 rtl/mapper_sdram_read_bridge.sv | 121 ++++++++++++
 tb/tb_mapper_sdram_read_bridge.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mapper_sdram_read_bridge.sv
// Turns each mapped CPU read into one SDRAM read over a level req/ack handshake, stalling the CPU meanwhile.
// Optional one-entry last-hit cache: define MAPPER_SDRAM_LASTHIT_CACHE_EN.
module mapper_sdram_read_bridge #(
  parameter int ADDR_W         = 27,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_rd,
  input  logic              map_ram_cs,
  input  logic [ADDR_W-1:0] map_addr,
  input  logic              cache_inv,
  output logic              sdram_req,
  output logic [ADDR_W-1:0] sdram_addr,
  input  logic              sdram_ack,
  input  logic [7:0]        sdram_dout,
  output logic              cpu_wait,
  output logic [7:0]        cpu_data,
  output logic              cpu_data_valid,
  output logic              err_overrun,
  output logic              err_timeout
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             start, hit, ack_ok, last;

  assign start  = cpu_req & cpu_rd & map_ram_cs;
  // An ack only counts while our request is up; late or stray acks fall through.
  assign ack_ok = sdram_ack & sdram_req;
  assign last   = (count == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MAPPER_SDRAM_LASTHIT_CACHE_EN
  logic              c_valid;
  logic [ADDR_W-1:0] c_tag;
  logic [7:0]        c_byte;

  assign hit = c_valid && (c_tag == map_addr);

  // Invalidate beats a simultaneous fill so a stale byte can never be served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_valid <= 1'b0;
      c_tag   <= '0;
      c_byte  <= 8'h00;
    end else if (ack_ok) begin
      c_valid <= ~cache_inv;
      c_tag   <= sdram_addr;
      c_byte  <= sdram_dout;
    end else if (cache_inv) begin
      c_valid <= 1'b0;
    end
  end
`else
  logic unused_cache_inv;
  assign unused_cache_inv = cache_inv;
  assign hit = 1'b0;
`endif

  assign cpu_wait = (state == IDLE && start && !hit) || state == REQ || state == WAIT_ACK;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      sdram_req      <= 1'b0;
      sdram_addr     <= '0;
      cpu_data       <= 8'hFF;
      cpu_data_valid <= 1'b0;
      err_overrun    <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      cpu_data_valid <= 1'b0;
      if (cpu_req && state != IDLE) err_overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (cpu_req && cpu_rd) begin
            if (!map_ram_cs) begin
              cpu_data       <= 8'hFF;
              cpu_data_valid <= 1'b1;
              state          <= DONE;
`ifdef MAPPER_SDRAM_LASTHIT_CACHE_EN
            end else if (hit) begin
              cpu_data       <= c_byte;
              cpu_data_valid <= 1'b1;
              state          <= DONE;
`endif
            end else begin
              sdram_addr <= map_addr;
              sdram_req  <= 1'b1;
              count      <= '0;
              state      <= REQ;
            end
          end
        end
        REQ, WAIT_ACK: begin
          if (ack_ok) begin
            cpu_data       <= sdram_dout;
            cpu_data_valid <= 1'b1;
            sdram_req      <= 1'b0;
            state          <= DONE;
          end else if (state == REQ) begin
            state <= WAIT_ACK;
          end else if (last) begin
            cpu_data       <= 8'hFF;
            cpu_data_valid <= 1'b1;
            sdram_req      <= 1'b0;
            err_timeout    <= 1'b1;
            state          <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mapper_sdram_read_bridge.sv
// Scoreboard bench: expected {byte, cycle} pushed at each CPU start, popped on cpu_data_valid.
module tb_mapper_sdram_read_bridge;
  localparam int AW = 27;
  localparam int TO = 8;

  logic          clk = 0, reset = 1;
  logic          cpu_req = 0, cpu_rd = 0, map_ram_cs = 0, cache_inv = 0;
  logic [AW-1:0] map_addr = '0;
  logic          sdram_req, sdram_ack = 0;
  logic [AW-1:0] sdram_addr;
  logic [7:0]    sdram_dout = 8'h00;
  logic          cpu_wait, cpu_data_valid, err_overrun, err_timeout;
  logic [7:0]    cpu_data;

  int checks = 0, errors = 0, cyc = 0;

  typedef struct {logic [7:0] d; int c;} exp_t;
  exp_t exp_q[$];

  mapper_sdram_read_bridge #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_rd(cpu_rd), .map_ram_cs(map_ram_cs),
    .map_addr(map_addr), .cache_inv(cache_inv), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .sdram_dout(sdram_dout), .cpu_wait(cpu_wait), .cpu_data(cpu_data),
    .cpu_data_valid(cpu_data_valid), .err_overrun(err_overrun), .err_timeout(err_timeout));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && cpu_data_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid got data %h at cyc %0d, required no completion", cpu_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (cpu_data !== e.d || cyc != e.c) begin
          errors++;
          $display("FAIL completion got %h at cyc %0d, required %h at cyc %0d", cpu_data, cyc, e.d, e.c);
        end
      end
    end
  end

  task automatic run_read(input logic [AW-1:0] a, input logic cs, input int ack_n, input logic [7:0] d,
                          input int ovr_at, input int exp_lat, input logic [7:0] exp_data,
                          output int wait_cnt, output int req_cnt, output int rises);
    int start, rise;
    logic prev;
    bit seen;
    wait_cnt = 0; req_cnt = 0; rises = 0; rise = -1; prev = 0; seen = 0;
    @(negedge clk);
    cpu_req = 1; cpu_rd = 1; map_ram_cs = cs; map_addr = a; start = cyc;
    exp_q.push_back('{exp_data, start + exp_lat});
    #1 if (cpu_wait) wait_cnt++;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      cpu_req = 0; sdram_ack = 0; sdram_dout = 8'($urandom); map_addr = a ^ 27'h0555_555;
      if (ovr_at > 0 && cyc == start + ovr_at) cpu_req = 1;
      if (sdram_req) begin
        req_cnt++;
        if (!prev) rises++;
        if (rise < 0) rise = cyc;
      end
      prev = sdram_req;
      if (ack_n >= 0 && rise >= 0 && cyc == rise + ack_n) begin
        sdram_ack = 1; sdram_dout = d;
      end
      if (cpu_data_valid) seen = 1;
      #1 if (cpu_wait) wait_cnt++;
    end
    @(negedge clk);
    sdram_ack = 0; cpu_req = 0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL read_timeout no cpu_data_valid within 40 cycles for addr %h", a);
    end
  endtask

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    chk("reset_sdram_req", int'(sdram_req), 0);
    chk("reset_sdram_addr", int'(sdram_addr), 0);
    chk("reset_cpu_data", int'(cpu_data), 8'hFF);
    chk("reset_wait_valid", int'({cpu_wait, cpu_data_valid}), 0);
    chk("reset_errs", int'({err_overrun, err_timeout}), 0);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_mapped;
    int w, r, ri;
    run_read(27'h0004123, 1, 3, 8'h5A, -1, 5, 8'h5A, w, r, ri);
    chk("mapped_wait", w, 5);
    chk("mapped_req_cycles", r, 4);
    chk("mapped_addr", int'(sdram_addr), 27'h0004123);
    run_read(27'h7FFFFFF, 1, 0, 8'h3C, -1, 2, 8'h3C, w, r, ri);
    chk("ack0_wait", w, 2);
    chk("ack0_addr", int'(sdram_addr), 27'h7FFFFFF);
    run_read(27'h0000001, 1, 1, 8'h00, -1, 3, 8'h00, w, r, ri);
    chk("ack1_wait", w, 3);
  endtask

  task automatic test_unmapped;
    int w, r, ri;
    run_read(27'h7FFFFFF, 0, -1, 8'h11, -1, 1, 8'hFF, w, r, ri);
    chk("unmapped_wait", w, 0);
    chk("unmapped_req", r, 0);
  endtask

  task automatic test_write_ignored;
    int r;
    r = 0;
    @(negedge clk);
    cpu_req = 1; cpu_rd = 0; map_ram_cs = 1; map_addr = 27'h0000123;
    #1 chk("write_wait", int'(cpu_wait), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cpu_req = 0;
      if (sdram_req) r++;
    end
    chk("write_req", r, 0);
  endtask

  task automatic test_ack_last_cycle;
    int w, r, ri;
    run_read(27'h0000200, 1, TO, 8'hC3, -1, TO + 2, 8'hC3, w, r, ri);
    chk("acklast_req_cycles", r, TO + 1);
    chk("acklast_no_timeout", int'(err_timeout), 0);
  endtask

  task automatic test_timeout;
    int w, r, ri;
    run_read(27'h0000300, 1, -1, 8'h00, -1, TO + 2, 8'hFF, w, r, ri);
    chk("timeout_req_cycles", r, TO + 1);
    chk("timeout_wait", w, TO + 2);
    chk("timeout_err", int'(err_timeout), 1);
    @(negedge clk);
    sdram_ack = 1; sdram_dout = 8'h77;
    @(negedge clk);
    sdram_ack = 0;
    repeat (2) @(negedge clk);
    chk("stray_ack_data", int'(cpu_data), 8'hFF);
    chk("stray_ack_req", int'(sdram_req), 0);
  endtask

  task automatic test_overrun;
    int w, r, ri;
    chk("overrun_clear", int'(err_overrun), 0);
    run_read(27'h0000400, 1, 3, 8'h99, 3, 5, 8'h99, w, r, ri);
    chk("overrun_err", int'(err_overrun), 1);
    chk("overrun_rises", ri, 1);
    chk("overrun_req_cycles", r, 4);
    chk("overrun_addr", int'(sdram_addr), 27'h0000400);
  endtask

  task automatic test_async_reset;
    int w, r, ri;
    @(negedge clk);
    cpu_req = 1; cpu_rd = 1; map_ram_cs = 1; map_addr = 27'h0000500;
    @(negedge clk);
    cpu_req = 0;
    repeat (2) @(negedge clk);
    chk("midreset_req_before", int'(sdram_req), 1);
    #2 reset = 1;
    #1;
    chk("midreset_req", int'(sdram_req), 0);
    chk("midreset_wait", int'(cpu_wait), 0);
    chk("midreset_valid", int'(cpu_data_valid), 0);
    repeat (2) @(negedge clk);
    chk("midreset_addr", int'(sdram_addr), 0);
    reset = 0;
    run_read(27'h0000600, 1, 2, 8'h42, -1, 4, 8'h42, w, r, ri);
    chk("after_reset_wait", w, 4);
  endtask

  task automatic test_cache;
    int w, r, ri;
    run_read(27'h0008000, 1, 2, 8'hA5, -1, 4, 8'hA5, w, r, ri);
`ifdef MAPPER_SDRAM_LASTHIT_CACHE_EN
    run_read(27'h0008000, 1, 2, 8'h00, -1, 1, 8'hA5, w, r, ri);
    chk("hit_req", r, 0);
    chk("hit_wait", w, 0);
`else
    run_read(27'h0008000, 1, 2, 8'h5B, -1, 4, 8'h5B, w, r, ri);
    chk("nocache_req", r, 3);
    chk("nocache_wait", w, 4);
`endif
    @(negedge clk);
    cache_inv = 1;
    @(negedge clk);
    cache_inv = 0;
    run_read(27'h0008000, 1, 1, 8'h3C, -1, 3, 8'h3C, w, r, ri);
    chk("inv_req", r, 2);
`ifdef MAPPER_SDRAM_LASTHIT_CACHE_EN
    run_read(27'h0008000, 1, 1, 8'h00, -1, 1, 8'h3C, w, r, ri);
    chk("refill_hit_req", r, 0);
    run_read(27'h0008001, 1, 0, 8'hE7, -1, 2, 8'hE7, w, r, ri);
    chk("other_addr_miss", r, 1);
`endif
  endtask

  initial begin
    test_reset();
    test_mapped();
    test_unmapped();
    test_write_ignored();
    test_ack_last_cycle();
    test_timeout();
    test_overrun();
    test_async_reset();
    test_cache();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
